// File: rtl/sobol_job_scheduler.sv
// Round-robin job scheduler: grants one requester at a time and forwards exactly
// that job's count of Sobol points, tagged with requester id, sample index and tlast.
module sobol_job_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int COUNT_BITS = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ID_BITS    = $clog2(NUM_REQ)
) (
  input  logic                          s00_axis_aclk,
  input  logic                          s00_axis_aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*COUNT_BITS-1:0] req_count,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          s00_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]         s00_axis_tdata,
  output logic                          s00_axis_tready,
  output logic                          m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]         m00_axis_tdata,
  output logic [ID_BITS-1:0]            m00_axis_tdest,
  output logic [COUNT_BITS-1:0]         m00_axis_tuser,
  output logic                          m00_axis_tlast,
  input  logic                          m00_axis_tready,
  output logic                          done_valid,
  output logic [ID_BITS-1:0]            done_id,
  output logic                          busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [ID_BITS-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]      job_id_q, job_id_d;
  logic [COUNT_BITS-1:0]   remaining_q, remaining_d;
  logic [COUNT_BITS-1:0]   idx_q, idx_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic [ID_BITS-1:0]      m_tdest_q, m_tdest_d;
  logic [COUNT_BITS-1:0]   m_tuser_q, m_tuser_d;
  logic                    m_tlast_q, m_tlast_d;
  logic                    done_valid_q, done_valid_d;
  logic [ID_BITS-1:0]      done_id_q, done_id_d;
  logic                    pend_q, pend_d;
  logic [ID_BITS-1:0]      pend_id_q, pend_id_d;

  logic [ID_BITS-1:0]      grant;
  logic                    grant_found;
  logic [COUNT_BITS-1:0]   grant_count;
  logic                    job_accept;
  logic                    zero_accept;
  logic                    in_fire;
  logic                    tlast_fire;

  always_comb begin : grant_search
    int cand;
    cand        = 0;
    grant       = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[ID_BITS'(cand)]) begin
        grant_found = 1'b1;
        grant       = ID_BITS'(cand);
      end
    end
  end

  assign grant_count = req_count[grant*COUNT_BITS +: COUNT_BITS];
  // Gated by reset so every output reads 0 while reset is held.
  assign req_ready   = (state_q == IDLE && grant_found && s00_axis_aresetn)
                       ? (NUM_REQ'(1) << grant) : '0;
  assign job_accept  = |(req_valid & req_ready);
  assign zero_accept = job_accept && (grant_count == '0);

  assign s00_axis_tready = (state_q == STREAM) && (!m_tvalid_q || m00_axis_tready);
  assign in_fire         = s00_axis_tvalid && s00_axis_tready;
  assign tlast_fire      = m_tvalid_q && m00_axis_tready && m_tlast_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    job_id_d     = job_id_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    m_tdest_d    = m_tdest_q;
    m_tuser_d    = m_tuser_q;
    m_tlast_d    = m_tlast_q;
    done_valid_d = 1'b0;
    done_id_d    = done_id_q;
    pend_d       = pend_q;
    pend_id_d    = pend_id_q;

    case (state_q)
      IDLE: begin
        if (job_accept) begin
          job_id_d    = grant;
          remaining_d = grant_count;
          idx_d       = '0;
          rr_ptr_d    = (grant == ID_BITS'(NUM_REQ - 1)) ? '0 : grant + ID_BITS'(1);
          if (grant_count != '0) state_d = STREAM;
        end
      end
      STREAM: begin
        if (in_fire) begin
          remaining_d = remaining_q - COUNT_BITS'(1);
          idx_d       = idx_q + COUNT_BITS'(1);
          if (remaining_q == COUNT_BITS'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_fire) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s00_axis_tdata;
      m_tdest_d  = job_id_q;
      m_tuser_d  = idx_q;
      m_tlast_d  = (remaining_q == COUNT_BITS'(1));
    end else if (m00_axis_tready) begin
      m_tvalid_d = 1'b0;
    end

    // A tlast completion takes the done slot; a colliding zero-count done waits one cycle.
    if (tlast_fire) begin
      done_valid_d = 1'b1;
      done_id_d    = m_tdest_q;
      if (zero_accept) begin
        pend_d    = 1'b1;
        pend_id_d = grant;
      end
    end else if (pend_q) begin
      done_valid_d = 1'b1;
      done_id_d    = pend_id_q;
      pend_d       = zero_accept;
      if (zero_accept) pend_id_d = grant;
    end else if (zero_accept) begin
      done_valid_d = 1'b1;
      done_id_d    = grant;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      job_id_q     <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tdest_q    <= '0;
      m_tuser_q    <= '0;
      m_tlast_q    <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      pend_q       <= 1'b0;
      pend_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      job_id_q     <= job_id_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tdest_q    <= m_tdest_d;
      m_tuser_q    <= m_tuser_d;
      m_tlast_q    <= m_tlast_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      pend_q       <= pend_d;
      pend_id_q    <= pend_id_d;
    end
  end

  assign m00_axis_tvalid = m_tvalid_q;
  assign m00_axis_tdata  = m_tdata_q;
  assign m00_axis_tdest  = m_tdest_q;
  assign m00_axis_tuser  = m_tuser_q;
  assign m00_axis_tlast  = m_tlast_q;
  assign done_valid      = done_valid_q;
  assign done_id         = done_id_q;
  assign busy            = (state_q == STREAM) || m_tvalid_q;

endmodule

// File: tb/tb_sobol_job_scheduler.sv
// Bench for sobol_job_scheduler: grant table, directed jobs, backpressure, reset,
// and randomized job mixes checked against a queue-based reference model.
module tb_sobol_job_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int COUNT_BITS = 16;
  localparam int DATA_WIDTH = 64;
  localparam int ID_BITS    = 2;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*COUNT_BITS-1:0] req_count;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          s_tvalid;
  logic [DATA_WIDTH-1:0]         s_tdata;
  logic                          s_tready;
  logic                          m_tvalid;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic [ID_BITS-1:0]            m_tdest;
  logic [COUNT_BITS-1:0]         m_tuser;
  logic                          m_tlast;
  logic                          m_tready;
  logic                          done_valid;
  logic [ID_BITS-1:0]            done_id;
  logic                          busy;

  always #5 clk = ~clk;

  sobol_job_scheduler #(
    .NUM_REQ(NUM_REQ), .COUNT_BITS(COUNT_BITS), .DATA_WIDTH(DATA_WIDTH), .ID_BITS(ID_BITS)
  ) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .req_valid(req_valid), .req_count(req_count), .req_ready(req_ready),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tready(s_tready),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tdata(m_tdata), .m00_axis_tdest(m_tdest),
    .m00_axis_tuser(m_tuser), .m00_axis_tlast(m_tlast), .m00_axis_tready(m_tready),
    .done_valid(done_valid), .done_id(done_id), .busy(busy)
  );

  typedef struct {
    logic [63:0] data;
    int          dest;
    int          user;
    bit          last;
  } beat_t;

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] exp_ready;
    int                 exp_id;
  } gvec_t;

  int    n_cmp  = 0;
  int    n_fail = 0;
  int    jobq[NUM_REQ][$];
  int    mptr;
  gvec_t gt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, " req_ready"}, req_ready, 0);
    chk({tag, " s_tready"}, s_tready, 0);
    chk({tag, " m_tvalid"}, m_tvalid, 0);
    chk({tag, " m_tdata"}, m_tdata, 0);
    chk({tag, " m_tdest"}, m_tdest, 0);
    chk({tag, " m_tuser"}, m_tuser, 0);
    chk({tag, " m_tlast"}, m_tlast, 0);
    chk({tag, " done_valid"}, done_valid, 0);
    chk({tag, " done_id"}, done_id, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (jobq[i].size() > 0);
      req_count[i*COUNT_BITS +: COUNT_BITS] =
        (jobq[i].size() > 0) ? COUNT_BITS'(jobq[i][0]) : '0;
    end
  endtask

  task automatic drive_stream(input int mode, input int ph);
    case (mode)
      0: begin s_tvalid = 1'b1; m_tready = 1'b1; end
      1: begin s_tvalid = 1'b1; m_tready = (ph % 3 == 0); end
      default: begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        m_tready = ($urandom_range(0, 4) > 1);
      end
    endcase
  endtask

  // Reference: round-robin over pending job queues gives the grant order and the
  // exact beat stream; completion ids queue up and drain one per cycle.
  task automatic run_jobs(input int mode, input logic [63:0] dbase, input string tag);
    beat_t eb[$];
    int    eg[$];
    int    dq[$];
    int    pos[NUM_REQ];
    int    sent, nb, cyc, ph, g, cnt;
    bit    prev_tl, prev_z, prev_stall, fin, in_fire, out_fire, acc;
    int    prev_tl_id, prev_z_id;
    beat_t held, b;

    sent = 0; nb = 0; cyc = 0; ph = 0;
    prev_tl = 0; prev_z = 0; prev_stall = 0; fin = 0;
    prev_tl_id = 0; prev_z_id = 0;
    for (int i = 0; i < NUM_REQ; i++) pos[i] = 0;

    while (1) begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (mptr + k) % NUM_REQ;
        if (g < 0 && pos[c] < jobq[c].size()) g = c;
      end
      if (g < 0) break;
      eg.push_back(g);
      cnt = jobq[g][pos[g]];
      for (int s = 0; s < cnt; s++) begin
        b.data = dbase + 64'(nb);
        b.dest = g;
        b.user = s;
        b.last = (s == cnt - 1);
        eb.push_back(b);
        nb++;
      end
      pos[g]++;
      mptr = (g + 1) % NUM_REQ;
    end

    drive_reqs();
    s_tdata = dbase;
    drive_stream(mode, ph);

    while (!fin) begin
      @(negedge clk);
      if (prev_tl) dq.push_back(prev_tl_id);
      if (prev_z)  dq.push_back(prev_z_id);
      if (dq.size() > 0) begin
        chk({tag, " done_valid"}, done_valid, 1);
        chk({tag, " done_id"}, done_id, dq.pop_front());
      end else begin
        chk({tag, " done_valid idle"}, done_valid, 0);
      end

      if (prev_stall) begin
        chk({tag, " stall tvalid"}, m_tvalid, 1);
        chk({tag, " stall tdata"}, m_tdata, held.data);
        chk({tag, " stall tdest"}, m_tdest, held.dest);
        chk({tag, " stall tuser"}, m_tuser, held.user);
        chk({tag, " stall tlast"}, m_tlast, held.last);
      end
      if (m_tvalid && !m_tready) chk({tag, " s_tready while stalled"}, s_tready, 0);

      in_fire  = s_tvalid && s_tready;
      out_fire = m_tvalid && m_tready;
      acc = 0;
      g   = 0;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && req_ready[i]) begin acc = 1; g = i; end

      prev_z = 0;
      if (acc) begin
        chk({tag, " req_ready onehot"}, $onehot(req_ready), 1);
        if (eg.size() > 0) chk({tag, " grant"}, g, eg.pop_front());
        else fail_now({tag, " unexpected grant"});
        prev_z    = (jobq[g][0] == 0);
        prev_z_id = g;
      end

      prev_tl    = out_fire && m_tlast;
      prev_tl_id = int'(m_tdest);
      if (out_fire) begin
        if (eb.size() > 0) begin
          b = eb.pop_front();
          chk({tag, " tdata"}, m_tdata, b.data);
          chk({tag, " tdest"}, m_tdest, b.dest);
          chk({tag, " tuser"}, m_tuser, b.user);
          chk({tag, " tlast"}, m_tlast, b.last);
        end else begin
          fail_now({tag, " extra output beat"});
        end
      end

      prev_stall = m_tvalid && !m_tready;
      held.data  = m_tdata;
      held.dest  = int'(m_tdest);
      held.user  = int'(m_tuser);
      held.last  = m_tlast;
      cyc++;
      fin = (eb.size() == 0) && (eg.size() == 0) && (dq.size() == 0) &&
            !prev_tl && !prev_z && !(m_tvalid && !out_fire);
      if (!fin && cyc >= 2000) begin
        fail_now({tag, " timeout waiting for jobs to drain"});
        fin = 1;
      end

      @(posedge clk);
      #1;
      if (in_fire) sent++;
      if (acc) void'(jobq[g].pop_front());
      ph++;
      drive_reqs();
      s_tdata = dbase + 64'(sent);
      drive_stream(mode, ph);
    end
    for (int i = 0; i < NUM_REQ; i++) jobq[i].delete();
    drive_reqs();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
  endtask

  initial begin
    int nout, cyc;
    bit granted, fire;

    gt[0] = '{4'b1111, 4'b0001, 0};
    gt[1] = '{4'b0001, 4'b0001, 0};
    gt[2] = '{4'b1100, 4'b0100, 2};
    gt[3] = '{4'b0110, 4'b0010, 1};
    gt[4] = '{4'b1011, 4'b1000, 3};
    gt[5] = '{4'b1000, 4'b1000, 3};
    gt[6] = '{4'b0010, 4'b0010, 1};

    // Reset state, with inputs active to confirm outputs are forced low.
    rst_n     = 1'b0;
    req_valid = '1;
    req_count = '1;
    s_tvalid  = 1'b1;
    s_tdata   = 64'h1234;
    m_tready  = 1'b1;
    #12;
    chk_outs_zero("reset");
    @(posedge clk); #1;
    req_valid = '0;
    req_count = '0;
    s_tvalid  = 1'b0;
    rst_n     = 1'b1;
    mptr      = 0;

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) jobq[i].push_back(1);
    run_jobs(0, 64'h40, "fairness");

    // Zero-count grant table: no beats, done at T+1, s_tready never high.
    for (int t = 0; t < 7; t++) begin
      req_valid = gt[t].mask;
      req_count = '0;
      @(negedge clk);
      chk($sformatf("table[%0d] req_ready", t), req_ready, gt[t].exp_ready);
      chk($sformatf("table[%0d] s_tready", t), s_tready, 0);
      chk($sformatf("table[%0d] done before", t), done_valid, 0);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("table[%0d] done_valid", t), done_valid, 1);
      chk($sformatf("table[%0d] done_id", t), done_id, gt[t].exp_id);
      chk($sformatf("table[%0d] s_tready after", t), s_tready, 0);
      chk($sformatf("table[%0d] m_tvalid", t), m_tvalid, 0);
      @(posedge clk); #1;
    end
    mptr = (gt[6].exp_id + 1) % NUM_REQ;

    jobq[2].push_back(3);
    run_jobs(0, 64'hA, "single");

    jobq[0].push_back(4);
    run_jobs(1, 64'h100, "backpressure");

    // tlast accept and zero-count accept land on the same edge.
    jobq[1].push_back(2);
    jobq[2].push_back(0);
    jobq[3].push_back(0);
    run_jobs(0, 64'h200, "collide");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int nj;
        nj = $urandom_range(0, 3);
        for (int j = 0; j < nj; j++) jobq[i].push_back($urandom_range(0, 6));
      end
      run_jobs(2, {$urandom, $urandom}, $sformatf("random%0d", r));
    end

    // Reset in the middle of a 5-beat job from requester 2.
    req_count = '0;
    req_count[2*COUNT_BITS +: COUNT_BITS] = 16'd5;
    req_valid = 4'b0100;
    s_tvalid  = 1'b1;
    s_tdata   = 64'h300;
    m_tready  = 1'b1;
    nout = 0; cyc = 0; granted = 0;
    while (nout < 2 && cyc < 50) begin
      @(negedge clk);
      if (req_valid[2] && req_ready[2]) granted = 1;
      fire = m_tvalid && m_tready;
      @(posedge clk); #1;
      if (granted) req_valid = '0;
      s_tdata = s_tdata + 64'd1;
      if (fire) nout++;
      cyc++;
    end
    if (nout < 2) fail_now("midreset timeout waiting for 2 beats");
    chk("midreset busy before", busy, 1);
    req_valid = '1;
    req_count = '1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs_zero("midreset async");
    @(negedge clk);
    chk_outs_zero("midreset held");
    @(posedge clk); #1;
    req_valid = '0;
    req_count = '0;
    s_tvalid  = 1'b0;
    rst_n     = 1'b1;
    mptr      = 0;
    jobq[1].push_back(1);
    jobq[3].push_back(2);
    run_jobs(0, 64'h500, "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
